// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - 8N1 UART receiver packing byte pairs into a 16-bit word FIFO
// Optional even-parity frame support is compiled in with `define UART_RX_PARITY_EN.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 4,
  parameter int AFULL_LVL    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        rx,
  input  logic        rd_en,
  output logic [15:0] data_out,
  output logic        fifo_empty,
  output logic        fifo_afull,
  output logic        fifo_full,
  output logic        frame_err,
`ifdef UART_RX_PARITY_EN
  output logic        parity_err,
`endif
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   occ_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t      state;
  logic        rx_s1, rx_s2, rx_d;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  hi_byte;
  logic        phase;
  logic        discard;
  logic        push;
  logic [15:0] push_word;
  ptr_t        wr_ptr, rd_ptr;
  occ_t        count;
  logic [15:0] mem [DEPTH];
  logic        do_pop, do_push;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop  = rd_en && (count != occ_t'(0));
  assign do_push = push && ((count != occ_t'(DEPTH)) || do_pop);

  assign fifo_empty = (count == occ_t'(0));
  assign fifo_full  = (count == occ_t'(DEPTH));
  assign fifo_afull = (count >= occ_t'(AFULL_LVL));
  assign data_out   = fifo_empty ? 16'h0000 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_d      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      hi_byte   <= '0;
      phase     <= 1'b0;
      discard   <= 1'b0;
      push      <= 1'b0;
      push_word <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (ce) begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
      push  <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_d && !rx_s2) begin
            state   <= START;
            cnt     <= '0;
            bit_idx <= '0;
            discard <= 1'b0;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= STOP;
            if ((^shreg) != rx_s2) begin
              parity_err <= 1'b1;
              discard    <= 1'b1;
              phase      <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s2) begin
              state <= IDLE;
              if (!discard) begin
                if (!phase) begin
                  hi_byte <= shreg;
                  phase   <= 1'b1;
                end else begin
                  push      <= 1'b1;
                  push_word <= {hi_byte, shreg};
                  phase     <= 1'b0;
                end
              end
            end else begin
              frame_err <= 1'b1;
              phase     <= 1'b0;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_IDLE: if (rx_s2) state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (do_pop) rd_ptr <= rd_ptr + ptr_t'(1);
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      else if (push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + occ_t'(1);
        2'b01:   count <= count - occ_t'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ce && do_push) mem[wr_ptr] <= push_word;
  end

endmodule
